// File: rtl/clock_divider_bank.sv
// clock_divider_bank: NUM_CH independent integer clock dividers on the
// 19.2 kHz system clock. Each channel produces a registered divided clock
// (high for floor(N/2) of every N cycles) and a one-cycle tick on the last
// cycle of each period. Ratios are written into a shadow register and only
// take effect at a period boundary, so a running clock never sees a short
// or stretched pulse.
module clock_divider_bank #(
  parameter  int NUM_CH      = 4,
  parameter  int DIV_W       = 8,
  parameter  int DEFAULT_DIV = 2,
  localparam int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock_00_0192,
  input  logic              reset,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [DIV_W-1:0]  div_val,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic              sync_restart,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending,
  output logic              cfg_err
);

  // A write is legal only for an existing channel and a ratio of at least 2;
  // a ratio of 0 or 1 cannot give a period with both a high and a low phase.
  logic sel_ok;
  logic val_ok;
  logic wr_ok;
  logic wr_bad;

  assign sel_ok = (int'(div_sel) < NUM_CH);
  assign val_ok = (div_val >= DIV_W'(2));
  assign wr_ok  = div_wr && sel_ok && val_ok;
  assign wr_bad = div_wr && !(sel_ok && val_ok);

  // Sticky configuration error flag, cleared only by reset.
  always_ff @(posedge clock_00_0192 or posedge reset) begin
    if (reset) begin
      cfg_err <= 1'b0;
    end else if (wr_bad) begin
      cfg_err <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DIV_W-1:0] cnt_reg;
      logic [DIV_W-1:0] cnt_next;
      logic [DIV_W-1:0] active_reg;
      logic [DIV_W-1:0] active_next;
      logic [DIV_W-1:0] shadow_reg;
      logic [DIV_W-1:0] shadow_next;
      logic             pending_reg;
      logic             pending_next;
      logic             run_reg;
      logic             clk_reg;
      logic             clk_next;
      logic             tick_reg;
      logic             tick_next;
      logic             hit;
      logic             en;
      logic             boundary;
      logic             apply;

      assign en  = ch_enable[gi];
      assign hit = wr_ok && (int'(div_sel) == gi);

      // Next-state logic. A new ratio is taken whenever the channel is at a
      // point where no period is in progress: the wrap of a running period,
      // a phase-align restart, or while the channel is stopped. A write that
      // lands on such a point bypasses the shadow and is used directly.
      // Outputs are derived from the next count and ratio so that they are
      // registered on the same edge as the counter.
      always_comb begin
        boundary     = run_reg && en && (cnt_reg == active_reg - DIV_W'(1));
        apply        = !en || sync_restart || boundary;
        shadow_next  = hit ? div_val : shadow_reg;
        pending_next = pending_reg || hit;
        active_next  = active_reg;
        if (apply) begin
          pending_next = 1'b0;
          if (hit) begin
            active_next = div_val;
          end else if (pending_reg) begin
            active_next = shadow_reg;
          end
        end

        if (!en || sync_restart || !run_reg || boundary) begin
          cnt_next = '0;
        end else begin
          cnt_next = cnt_reg + DIV_W'(1);
        end

        clk_next  = en && (cnt_next < (active_next >> 1));
        tick_next = en && !sync_restart && (cnt_next == active_next - DIV_W'(1));
      end

      // Channel state and registered outputs.
      always_ff @(posedge clock_00_0192 or posedge reset) begin
        if (reset) begin
          cnt_reg     <= '0;
          active_reg  <= DIV_W'(DEFAULT_DIV);
          shadow_reg  <= DIV_W'(DEFAULT_DIV);
          pending_reg <= 1'b0;
          run_reg     <= 1'b0;
          clk_reg     <= 1'b0;
          tick_reg    <= 1'b0;
        end else begin
          cnt_reg     <= cnt_next;
          active_reg  <= active_next;
          shadow_reg  <= shadow_next;
          pending_reg <= pending_next;
          run_reg     <= en;
          clk_reg     <= clk_next;
          tick_reg    <= tick_next;
        end
      end

      assign clk_out[gi] = clk_reg;
      assign tick[gi]    = tick_reg;
      assign pending[gi] = pending_reg;
    end
  endgenerate

endmodule
